// File: rtl/gf16_pkg.sv
// GF(2^4) arithmetic definitions shared by the RS syndrome datapath.
// Field polynomial P(x) = x^4 + x^3 + 1, primitive element alpha = x.
package gf16_pkg;

    localparam int             GF_W    = 4;
    localparam logic [GF_W:0]  GF_POLY = 5'b11001;

    // alpha^i for i = 0..14; alpha^15 wraps back to 1.
    localparam logic [GF_W-1:0] ALPHA_POW [0:14] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001,
        4'b1011, 4'b1111, 4'b0111, 4'b1110, 4'b0101,
        4'b1010, 4'b1101, 4'b0011, 4'b0110, 4'b1100
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } syn_state_e;

    // Reference shift-and-add multiply; handy for constant folding and checks.
    function automatic logic [GF_W-1:0] gf16_mul(input logic [GF_W-1:0] a,
                                                 input logic [GF_W-1:0] b);
        logic [GF_W-1:0] acc;
        logic [GF_W-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[GF_W-1] ? ({x[GF_W-2:0], 1'b0} ^ GF_POLY[GF_W-1:0])
                          : {x[GF_W-2:0], 1'b0};
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf16_mastrovito_mul.sv
// Combinational 4x4 GF(16) multiplier: full polynomial product, then a
// fixed reduction of the x^4..x^6 terms modulo x^4 + x^3 + 1.
module gf16_mastrovito_mul
    import gf16_pkg::*;
(
    input  logic [GF_W-1:0] a,
    input  logic [GF_W-1:0] b,
    output logic [GF_W-1:0] p
);

    logic [2*GF_W-2:0] c;

    // Carry-less product c(x) = a(x) * b(x), degree up to 6.
    always_comb begin
        c = '0;
        for (int i = 0; i < GF_W; i++) begin
            for (int k = 0; k < GF_W; k++) begin
                c[i+k] = c[i+k] ^ (a[i] & b[k]);
            end
        end
    end

    // Reduction: x^4 = x^3+1, x^5 = x^3+x+1, x^6 = x^3+x^2+x+1.
    assign p[0] = c[0] ^ c[4] ^ c[5] ^ c[6];
    assign p[1] = c[1] ^ c[5] ^ c[6];
    assign p[2] = c[2] ^ c[6];
    assign p[3] = c[3] ^ c[4] ^ c[5] ^ c[6];

endmodule

// File: rtl/gf16_rs_syndrome.sv
// Streaming RS syndrome generator over GF(16). Symbols arrive highest
// degree first; each accepted symbol performs one Horner step
// S_j <= S_j * alpha^j + r for every syndrome in parallel. After N_SYM
// symbols the syndromes are held on out_syn until the consumer takes them.
module gf16_rs_syndrome
    import gf16_pkg::*;
#(
    parameter int N_SYM = 15,
    parameter int N_SYN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [GF_W-1:0]       in_sym,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [GF_W*N_SYN-1:0] out_syn,
    output logic                  out_err
);

    localparam logic [3:0] LAST = 4'(N_SYM - 1);

    syn_state_e                       state;
    logic [3:0]                       count;
    logic [N_SYN-1:0][GF_W-1:0]       syn;
    logic [N_SYN-1:0][GF_W-1:0]       prod;
    logic [N_SYN-1:0][GF_W-1:0]       syn_next;

    // One constant-operand multiplier per syndrome: syn[j-1] * alpha^j.
    for (genvar j = 0; j < N_SYN; j++) begin : g_syn
        gf16_mastrovito_mul u_mul (
            .a (syn[j]),
            .b (ALPHA_POW[j+1]),
            .p (prod[j])
        );
    end

    // Horner step; the first symbol of a codeword seeds every syndrome.
    always_comb begin
        syn_next = '0;
        for (int j = 0; j < N_SYN; j++) begin
            syn_next[j] = (state == IDLE) ? in_sym : (prod[j] ^ in_sym);
        end
    end

    assign in_ready = (state != DONE);
    assign out_syn  = syn;

    // Control FSM, symbol counter and syndrome registers; framing is by count only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            syn       <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        syn <= syn_next;
                        if (count == LAST) begin
                            count     <= '0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_err   <= |syn_next;
                        end else begin
                            count <= count + 4'd1;
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        syn       <= '0;
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf16_rs_syndrome.sv
// Self-checking bench for gf16_rs_syndrome. Expected syndromes come from a
// direct polynomial evaluation r(alpha^j) using log/antilog tables built here.
module tb_gf16_rs_syndrome;

    localparam int N_SYM = 15;
    localparam int N_SYN = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [3:0]           in_sym = 4'h0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [4*N_SYN-1:0]   out_syn;
    logic                 out_err;

    gf16_rs_syndrome #(.N_SYM(N_SYM), .N_SYN(N_SYN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_syn   (out_syn),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4*N_SYN-1:0] syn;
        logic               err;
    } exp_t;

    typedef logic [3:0] word_t [N_SYM];

    exp_t       sb[$];
    logic [3:0] pow_t [15];
    int         log_t [16];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    int         bubbles  = 0;

    // Stall cycles seen by the producer while the bubble monitor is armed.
    always @(posedge clk) begin
        if (mon_en && in_valid && !in_ready) bubbles <= bubbles + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input word_t w);
        exp_t       e;
        logic [3:0] s;
        int         deg;
        e = '0;
        for (int j = 1; j <= N_SYN; j++) begin
            s = 4'h0;
            for (int k = 0; k < N_SYM; k++) begin
                deg = N_SYM - 1 - k;
                if (w[k] != 4'h0) s = s ^ pow_t[(log_t[w[k]] + deg * j) % 15];
            end
            e.syn[4*(j-1) +: 4] = s;
            if (s != 4'h0) e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic send_word(input word_t w, input bit gaps);
        bit acc;
        int budget;
        sb.push_back(model(w));
        for (int k = 0; k < N_SYM; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_sym   = 4'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_sym   = w[k];
            budget   = 0;
            forever begin
                acc = in_ready;
                @(negedge clk);
                if (acc) break;
                budget++;
                if (budget > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: symbol %0d not accepted, in_ready=%b required 1", k, in_ready);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_output(input string name, input int budget);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (!out_valid && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid=%b required 1 within %0d cycles", name, out_valid, budget);
            return;
        end
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected: out_valid=1 with empty scoreboard", name);
            @(negedge clk);
            return;
        end
        e = sb.pop_front();
        if (out_syn !== e.syn) begin
            n_fail++;
            $display("FAIL %s_syn: got %h required %h", name, out_syn, e.syn);
        end
        n_checks++;
        if (out_err !== e.err) begin
            n_fail++;
            $display("FAIL %s_err: got %b required %b", name, out_err, e.err);
        end
        @(negedge clk);
    endtask

    function automatic word_t unit_word(input int pos);
        word_t w;
        for (int k = 0; k < N_SYM; k++) w[k] = 4'h0;
        w[pos] = 4'h1;
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int k = 0; k < N_SYM; k++) w[k] = 4'($urandom);
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_syn !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b err=%b syn=%h required 0 0 0", out_valid, out_err, out_syn);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        word_t w;
        for (int k = 0; k < N_SYM; k++) w[k] = 4'h0;
        out_ready = 1'b0;
        send_word(w, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_latency: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
        end
        out_ready = 1'b1;
        check_output("zero", 4);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_unit();
        out_ready = 1'b1;
        send_word(unit_word(N_SYM - 1), 1'b0);
        check_output("r0", 4);
        send_word(unit_word(0), 1'b0);
        check_output("r14", 4);
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        send_word(unit_word(N_SYM - 1), 1'b0);
        e = sb[0];
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_sym   = 4'($urandom);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_handshake: cycle %0d out_valid=%b in_ready=%b required 1 0", c, out_valid, in_ready);
            end
            n_checks++;
            if (out_syn !== e.syn || out_err !== e.err) begin
                n_fail++;
                $display("FAIL bp_stable: cycle %0d syn=%h err=%b required %h %b", c, out_syn, out_err, e.syn, e.err);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_output("bp", 4);
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        send_word(rand_word(), 1'b1);
        check_output("stall_a", 4);
        send_word(rand_word(), 1'b1);
        check_output("stall_b", 4);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_sym   = 4'($urandom_range(1, 15));
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_syn !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: syn=%h valid=%b required 0 0", out_syn, out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_word(unit_word(0), 1'b0);
        check_output("midreset_r14", 4);
    endtask

    task automatic test_back_to_back();
        word_t w1;
        word_t w2;
        w1 = rand_word();
        w2 = rand_word();
        out_ready = 1'b1;
        bubbles   = 0;
        mon_en    = 1'b1;
        fork
            begin
                send_word(w1, 1'b0);
                send_word(w2, 1'b0);
            end
            begin
                check_output("b2b_a", 40);
                check_output("b2b_b", 40);
            end
        join
        mon_en = 1'b0;
        n_checks++;
        if (bubbles !== 1) begin
            n_fail++;
            $display("FAIL b2b_bubbles: got %0d in_ready=0 cycles required 1", bubbles);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
    endtask

    initial begin
        pow_t[0] = 4'h1;
        for (int i = 1; i < 15; i++) begin
            pow_t[i] = pow_t[i-1][3] ? ({pow_t[i-1][2:0], 1'b0} ^ 4'b1001)
                                     : {pow_t[i-1][2:0], 1'b0};
        end
        for (int i = 0; i < 16; i++) log_t[i] = 0;
        for (int i = 0; i < 15; i++) log_t[pow_t[i]] = i;

        @(negedge clk);
        test_reset();
        test_zero();
        test_unit();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
